// File: rtl/i2c_reg_ctrl_if.sv
// Bus-interface and register-file signals of the I2C register controller.
// slave: the protocol controller; master: bus interface plus register file around it.
interface i2c_reg_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              i2c_start;
    logic              i2c_stop;
    logic [7:0]        i2c_byte;
    logic              i2c_byte_valid;
    logic              i2c_ack;
    logic              i2c_tx_req;
    logic [7:0]        i2c_tx_byte;
    logic              i2c_tx_valid;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        reg_rdata;
    logic              xfer_active;

    modport slave (
        input  i2c_start, i2c_stop, i2c_byte, i2c_byte_valid, i2c_tx_req, reg_rdata,
        output i2c_ack, i2c_tx_byte, i2c_tx_valid, reg_addr, reg_wdata, reg_write,
               reg_read, xfer_active
    );

    modport master (
        output i2c_start, i2c_stop, i2c_byte, i2c_byte_valid, i2c_tx_req, reg_rdata,
        input  i2c_ack, i2c_tx_byte, i2c_tx_valid, reg_addr, reg_wdata, reg_write,
               reg_read, xfer_active
    );
endinterface

// File: rtl/i2c_reg_ctrl.sv
// I2C register protocol layer: decodes device address and register pointer, issues register strobes.
// Latency: byte_valid -> ack/reg_write 1 cycle; tx_req -> tx_valid 3 cycles.
// Backpressure: none; a tx_req arriving while a read is in flight is held and serviced afterwards.
module i2c_reg_ctrl #(
    parameter logic [6:0] DEV_ADDR = 7'h62,
    parameter int         ADDR_W   = 3
) (
    input  logic          clk,
    input  logic          reset,
    i2c_reg_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, REGPTR, WRITE, READ_WAIT, READ_CAP, IGNORE
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] reg_addr_q;
    logic              ai;
    logic              ack_q;
    logic              tx_valid_q;
    logic              reg_write_q;
    logic              reg_read_q;
    logic              tx_pend;
    logic [7:0]        tx_byte_q;
    logic [7:0]        reg_wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            reg_addr_q  <= '0;
            ai          <= 1'b0;
            ack_q       <= 1'b0;
            tx_valid_q  <= 1'b0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            tx_pend     <= 1'b0;
            tx_byte_q   <= 8'h00;
            reg_wdata_q <= 8'h00;
        end else begin
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            // reg_addr presents the pointer as it was before any increment this cycle
            reg_addr_q  <= ptr;
            if (bus.i2c_start) begin
                state   <= ADDR;
                ack_q   <= 1'b0;
                tx_pend <= 1'b0;
            end else if (bus.i2c_stop) begin
                state   <= IDLE;
                ack_q   <= 1'b0;
                tx_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE, IGNORE: begin
                        if (bus.i2c_byte_valid) ack_q <= 1'b0;
                    end
                    ADDR: begin
                        if (bus.i2c_byte_valid) begin
                            if (bus.i2c_byte[7:1] == DEV_ADDR) begin
                                ack_q <= 1'b1;
                                state <= bus.i2c_byte[0] ? READ_WAIT : REGPTR;
                            end else begin
                                ack_q <= 1'b0;
                                state <= IGNORE;
                            end
                        end
                    end
                    REGPTR: begin
                        if (bus.i2c_byte_valid) begin
                            ai <= bus.i2c_byte[7];
                            if (bus.i2c_byte[6:ADDR_W] == '0) begin
                                ptr   <= bus.i2c_byte[ADDR_W-1:0];
                                ack_q <= 1'b1;
                            end else begin
                                ack_q <= 1'b0;
                            end
                            state <= WRITE;
                        end
                    end
                    WRITE: begin
                        if (bus.i2c_byte_valid) begin
                            reg_write_q <= 1'b1;
                            reg_wdata_q <= bus.i2c_byte;
                            ack_q       <= 1'b1;
                            if (ai) ptr <= ptr + PTR_ONE;
                        end
                    end
                    READ_WAIT: begin
                        if (bus.i2c_byte_valid) ack_q <= 1'b1;
                        // reg_read high means the register file is producing data this cycle
                        if (reg_read_q) begin
                            state <= READ_CAP;
                            if (bus.i2c_tx_req) tx_pend <= 1'b1;
                        end else if (bus.i2c_tx_req || tx_pend) begin
                            reg_read_q <= 1'b1;
                            tx_pend    <= 1'b0;
                        end
                    end
                    READ_CAP: begin
                        if (bus.i2c_byte_valid) ack_q <= 1'b1;
                        if (bus.i2c_tx_req) tx_pend <= 1'b1;
                        tx_byte_q  <= bus.reg_rdata;
                        tx_valid_q <= 1'b1;
                        if (ai) ptr <= ptr + PTR_ONE;
                        state <= READ_WAIT;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.i2c_ack      = ack_q;
    assign bus.i2c_tx_byte  = tx_byte_q;
    assign bus.i2c_tx_valid = tx_valid_q;
    assign bus.reg_addr     = reg_addr_q;
    assign bus.reg_wdata    = reg_wdata_q;
    assign bus.reg_write    = reg_write_q;
    assign bus.reg_read     = reg_read_q;
    assign bus.xfer_active  = (state != IDLE) && (state != IGNORE);
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Testbench for i2c_reg_ctrl: directed protocol scenarios plus random event streams
// checked against a transaction-level model of the register protocol.
module tb_i2c_reg_ctrl;
    localparam int M_IDLE = 0, M_ADDR = 1, M_PTR = 2, M_WR = 3, M_RD = 4, M_IGN = 5;

    logic clk;
    logic reset;
    logic mem_init;
    logic [7:0] mem [8];

    i2c_reg_ctrl_if #(.ADDR_W(3)) bus ();

    i2c_reg_ctrl #(.DEV_ADDR(7'h62), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read data, one cycle after reg_read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(i * 16);
        end else if (bus.reg_write) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
        end
        if (bus.reg_read) bus.reg_rdata <= mem[bus.reg_addr];
    end

    int wr_seen = 0;
    int rd_seen = 0;
    always @(negedge clk) begin
        if (reset && bus.reg_write) wr_seen++;
        if (reset && bus.reg_read)  rd_seen++;
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int         m_mode;
    logic [2:0] m_ptr;
    logic       m_ai;
    logic       m_ack;
    logic [7:0] exp_mem [8];
    int         exp_wr, exp_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_xfer();
        return (m_mode == M_ADDR) || (m_mode == M_PTR) || (m_mode == M_WR) || (m_mode == M_RD);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_ptr  = 3'd0;
        m_ai   = 1'b0;
        m_ack  = 1'b0;
    endtask

    task automatic do_start();
        bus.i2c_start = 1'b1;
        step();
        bus.i2c_start = 1'b0;
        m_mode = M_ADDR;
        m_ack  = 1'b0;
        chk("start_ack", bus.i2c_ack, m_ack);
        chk("start_xfer", bus.xfer_active, exp_xfer());
    endtask

    task automatic do_stop();
        bus.i2c_stop = 1'b1;
        step();
        bus.i2c_stop = 1'b0;
        m_mode = M_IDLE;
        m_ack  = 1'b0;
        chk("stop_ack", bus.i2c_ack, m_ack);
        chk("stop_xfer", bus.xfer_active, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic       exp_w;
        logic [2:0] wa;
        exp_w = 1'b0;
        wa    = m_ptr;
        case (m_mode)
            M_ADDR: begin
                if (b[7:1] == 7'h62) begin
                    m_ack  = 1'b1;
                    m_mode = b[0] ? M_RD : M_PTR;
                end else begin
                    m_ack  = 1'b0;
                    m_mode = M_IGN;
                end
            end
            M_PTR: begin
                m_ai = b[7];
                if (b[6:3] == 4'd0) begin
                    m_ptr = b[2:0];
                    m_ack = 1'b1;
                end else begin
                    m_ack = 1'b0;
                end
                m_mode = M_WR;
            end
            M_WR: begin
                exp_w = 1'b1;
                exp_mem[m_ptr] = b;
                exp_wr++;
                m_ack = 1'b1;
                if (m_ai) m_ptr = m_ptr + 3'd1;
            end
            M_RD:    m_ack = 1'b1;
            default: m_ack = 1'b0;
        endcase
        bus.i2c_byte       = b;
        bus.i2c_byte_valid = 1'b1;
        step();
        bus.i2c_byte_valid = 1'b0;
        chk("byte_ack", bus.i2c_ack, m_ack);
        chk("byte_wr", bus.reg_write, exp_w);
        if (exp_w) begin
            chk("wr_addr", bus.reg_addr, wa);
            chk("wr_data", bus.reg_wdata, b);
        end
        chk("byte_xfer", bus.xfer_active, exp_xfer());
    endtask

    // One read request; waits out the full read before returning.
    task automatic tx_request(output logic [7:0] d);
        int   lat;
        logic rd;
        rd  = (m_mode == M_RD);
        lat = 0;
        d   = 8'h00;
        bus.i2c_tx_req = 1'b1;
        step();
        bus.i2c_tx_req = 1'b0;
        chk("tx_rdstrobe", bus.reg_read, rd);
        for (int k = 1; k <= 6; k++) begin
            if (bus.i2c_tx_valid && lat == 0) begin
                lat = k;
                d   = bus.i2c_tx_byte;
            end
            if (k < 6) step();
        end
        chk("tx_latency", lat, rd ? 3 : 0);
        if (rd) begin
            chk("tx_data", d, exp_mem[m_ptr]);
            exp_rd++;
            if (m_ai) m_ptr = m_ptr + 3'd1;
        end
    endtask

    task automatic chk_strobes(input string tag);
        chk({tag, "_wrcnt"}, wr_seen, exp_wr);
        chk({tag, "_rdcnt"}, rd_seen, exp_rd);
    endtask

    logic [7:0] d;
    logic [7:0] got [2];
    int         nv;
    int         r;
    logic [7:0] b;

    initial begin
        reset = 1'b0;
        mem_init = 1'b1;
        bus.i2c_start = 1'b0;
        bus.i2c_stop = 1'b0;
        bus.i2c_byte = 8'h00;
        bus.i2c_byte_valid = 1'b0;
        bus.i2c_tx_req = 1'b0;
        model_reset();
        exp_wr = 0;
        exp_rd = 0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'(i * 16);
        repeat (3) step();
        chk("rst_ack", bus.i2c_ack, 1'b0);
        chk("rst_txbyte", bus.i2c_tx_byte, 8'h00);
        chk("rst_txvalid", bus.i2c_tx_valid, 1'b0);
        chk("rst_write", bus.reg_write, 1'b0);
        chk("rst_read", bus.reg_read, 1'b0);
        chk("rst_xfer", bus.xfer_active, 1'b0);
        mem_init = 1'b0;
        reset = 1'b1;
        step();

        // Pointer 6 with auto-increment, repeated START into read: wraps 7 -> 0
        do_start(); send_byte(8'hC4); send_byte(8'h86);
        do_start(); send_byte(8'hC5);
        tx_request(d); chk("s4_rd0", d, 8'h60);
        tx_request(d); chk("s4_rd1", d, 8'h70);
        tx_request(d); chk("s4_rd2", d, 8'h00);
        do_stop();

        do_start(); send_byte(8'hC4); send_byte(8'h83); send_byte(8'h11); send_byte(8'h22); do_stop();
        chk("s1_mem3", exp_mem[3], 8'h11);
        do_start(); send_byte(8'hC5); tx_request(d); chk("s1_ptr5", d, 8'h50); do_stop();

        do_start(); send_byte(8'hC4); send_byte(8'h07); send_byte(8'hAA); send_byte(8'hBB); do_stop();
        do_start(); send_byte(8'h50); send_byte(8'h01); do_stop();
        do_start(); send_byte(8'hC4); send_byte(8'h7F); send_byte(8'h33); do_stop();
        chk_strobes("directed");

        // START colliding with a data byte: byte dropped, back to address phase
        do_start(); send_byte(8'hC4); send_byte(8'h02);
        bus.i2c_start = 1'b1; bus.i2c_byte = 8'h99; bus.i2c_byte_valid = 1'b1;
        step();
        bus.i2c_start = 1'b0; bus.i2c_byte_valid = 1'b0;
        m_mode = M_ADDR; m_ack = 1'b0;
        chk("coll_wr", bus.reg_write, 1'b0);
        chk("coll_ack", bus.i2c_ack, 1'b0);
        chk("coll_xfer", bus.xfer_active, 1'b1);
        send_byte(8'hC4); send_byte(8'h02); send_byte(8'h44); do_stop();

        // Request arriving during capture is held and serviced afterwards
        do_start(); send_byte(8'hC4); send_byte(8'h81); do_start(); send_byte(8'hC5);
        nv = 0;
        bus.i2c_tx_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            bus.i2c_tx_req = (k == 2);
            if (bus.i2c_tx_valid) begin
                if (nv < 2) got[nv] = bus.i2c_tx_byte;
                nv++;
            end
        end
        chk("pend_count", nv, 2);
        chk("pend_d0", got[0], exp_mem[1]);
        chk("pend_d1", got[1], exp_mem[2]);
        exp_rd += 2;
        m_ptr = 3'd3;
        do_stop();
        chk_strobes("pending");

        // Reset in the middle of a read capture
        do_start(); send_byte(8'hC4); send_byte(8'h00); send_byte(8'h5A); do_stop();
        do_start(); send_byte(8'hC4); send_byte(8'h86); do_start(); send_byte(8'hC5);
        bus.i2c_tx_req = 1'b1;
        step();
        bus.i2c_tx_req = 1'b0;
        chk("rstmid_rd", bus.reg_read, 1'b1);
        exp_rd++;
        step();
        reset = 1'b0;
        #1;
        chk("rstmid_ack", bus.i2c_ack, 1'b0);
        chk("rstmid_txv", bus.i2c_tx_valid, 1'b0);
        chk("rstmid_txb", bus.i2c_tx_byte, 8'h00);
        chk("rstmid_rdst", bus.reg_read, 1'b0);
        chk("rstmid_xfer", bus.xfer_active, 1'b0);
        model_reset();
        repeat (2) step();
        chk("rstmid_hold_txv", bus.i2c_tx_valid, 1'b0);
        reset = 1'b1;
        step();
        do_start(); send_byte(8'hC5); tx_request(d); chk("rstmid_ptr0", d, 8'h5A); do_stop();
        chk_strobes("reset");

        // Random event streams
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 11);
            if (r < 2) do_start();
            else if (r == 2) do_stop();
            else if (r < 9) begin
                b = 8'($urandom);
                if (m_mode == M_ADDR && $urandom_range(0, 9) < 7)
                    b = ($urandom_range(0, 1) == 1) ? 8'hC5 : 8'hC4;
                else if (m_mode == M_PTR && $urandom_range(0, 3) != 0)
                    b = {1'($urandom), 4'd0, 3'($urandom)};
                send_byte(b);
            end else begin
                tx_request(d);
            end
        end
        chk_strobes("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
